// File: rtl/xosera_pkg.sv
// Shared definitions for the Xosera VRAM arbiter: bus-width defaults,
// the read-return owner enum and the wait-counter ceiling.
package xosera_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 16;

    // Which requester owns a VRAM cycle; NONE marks an idle or write cycle.
    typedef enum logic [1:0] {
        VID  = 2'd0,
        REGS = 2'd1,
        BLIT = 2'd2,
        NONE = 2'd3
    } owner_t;

    localparam logic [7:0] WAIT_MAX = 8'hFF;

endpackage

// File: rtl/vram_arb.sv
// Single-port VRAM arbiter: video has absolute priority, host registers and
// blitter share the remaining cycles round-robin. Macro VRAM_ARB_BLIT_EN
// enables the blitter port; without it the blitter inputs are ignored.
module vram_arb
    import xosera_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    input  logic              regs_req,
    input  logic              regs_wr,
    input  logic [ADDR_W-1:0] regs_addr,
    input  logic [DATA_W-1:0] regs_wdata,
    output logic              regs_ack,
    output logic              regs_valid,
    input  logic              blit_req,
    input  logic              blit_wr,
    input  logic [ADDR_W-1:0] blit_addr,
    input  logic [DATA_W-1:0] blit_wdata,
    output logic              blit_ack,
    output logic              blit_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              vram_sel,
    output logic              vram_wr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    owner_t     grant;
    owner_t     ret_owner;
    logic       rr_last_blit;   // 0 = REGS won last non-video slot, 1 = BLIT
    logic       blit_req_eff;
    logic [7:0] regs_wait;
    logic [7:0] blit_wait;

`ifdef VRAM_ARB_BLIT_EN
    assign blit_req_eff = blit_req;
`else
    assign blit_req_eff = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case chain leaves it unassigned and infers a latch.
    always_comb begin
        grant = NONE;
        if (!reset) begin
            if (vid_req)
                grant = VID;
            else if (regs_req && blit_req_eff)
                grant = rr_last_blit ? REGS : BLIT;
            else if (regs_req)
                grant = REGS;
            else if (blit_req_eff)
                grant = BLIT;
        end
    end

    always_comb begin
        vram_sel   = 1'b0;
        vram_wr    = 1'b0;
        vram_addr  = vid_addr;
        vram_wdata = regs_wdata;
        unique case (grant)
            VID: begin
                vram_sel = 1'b1;
            end
            REGS: begin
                vram_sel   = 1'b1;
                vram_wr    = regs_wr;
                vram_addr  = regs_addr;
                vram_wdata = regs_wdata;
            end
            BLIT: begin
                vram_sel   = 1'b1;
                vram_wr    = blit_wr;
                vram_addr  = blit_addr;
                vram_wdata = blit_wdata;
            end
            default: ;
        endcase
    end

    assign regs_ack = (grant == REGS);
    assign rd_data  = vram_rdata;

    // Valid strobes are masked during reset so a read granted just before
    // reset asserts never reports its data.
    assign vid_valid  = !reset && (ret_owner == VID);
    assign regs_valid = !reset && (ret_owner == REGS);

`ifdef VRAM_ARB_BLIT_EN
    assign blit_ack   = (grant == BLIT);
    assign blit_valid = !reset && (ret_owner == BLIT);
`else
    assign blit_ack   = 1'b0;
    assign blit_valid = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_blit <= 1'b0;
            ret_owner    <= NONE;
        end else begin
            if (grant == REGS || grant == BLIT)
                rr_last_blit <= (grant == BLIT);
            ret_owner <= (vram_sel && !vram_wr) ? grant : NONE;
        end
    end

    // Debug wait counters: count cycles spent requesting without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_wait <= 8'd0;
            blit_wait <= 8'd0;
        end else begin
            if (regs_ack)
                regs_wait <= 8'd0;
            else if (regs_req && regs_wait != WAIT_MAX)
                regs_wait <= regs_wait + 8'd1;

            if (grant == BLIT)
                blit_wait <= 8'd0;
            else if (blit_req_eff && blit_wait != WAIT_MAX)
                blit_wait <= blit_wait + 8'd1;
        end
    end

    logic unused_dbg;
`ifdef VRAM_ARB_BLIT_EN
    assign unused_dbg = ^{regs_wait, blit_wait};
`else
    assign unused_dbg = ^{regs_wait, blit_wait, blit_req, blit_wr, blit_addr, blit_wdata};
`endif

endmodule
